uart_rx_frame_parser: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its `o_rx_dv`/`o_rx_byte` byte strobe and parses framed packets of the form SOF, LEN, payload, CSUM.
- Store-and-forward: payload is buffered internally and released on a valid/ready stream only after the checksum passes.
- Errored frames are discarded and reported with a one-cycle error pulse and an error code.

---
 rtl/uart_frame_pkg.sv | 27 ++
 rtl/uart_frame_buf.sv | 36 +++
 rtl/uart_rx_frame_parser.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame_parser.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM state encoding,
// error codes reported on o_err_code, and the default start-of-frame marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_OVERRUN = 2'd0;
  localparam err_code_t ERR_LEN     = 2'd1;
  localparam err_code_t ERR_CSUM    = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_BYTE_DFLT = 8'hA5;

  // A length byte is usable when it names 1..max_len payload bytes.
  function automatic logic len_valid(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 register array, one synchronous
// write port and one asynchronous read port. Contents are not reset; the
// parser never reads a location it has not written in the current frame.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem_q [DEPTH];

  logic wr_in_range;
  logic rd_in_range;

  // Pointers are one bit wider than the array index (they must reach DEPTH);
  // out-of-range addresses are ignored on write and read back as zero.
  assign wr_in_range = (waddr_i < AW'(DEPTH));
  assign rd_in_range = (raddr_i < AW'(DEPTH));
  assign rdata_o     = rd_in_range ? mem_q[raddr_i[IW-1:0]] : 8'h00;

  // Store one payload byte per write strobe.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Store-and-forward parser for SOF/LEN/payload/CSUM frames arriving as byte
// strobes from a UART receiver. Payload is buffered and only streamed out on
// the valid/ready interface once the XOR checksum (LEN ^ payload) matches.
// Errored frames are dropped and reported with a one-cycle pulse plus code.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SOF_BYTE     = SOF_BYTE_DFLT,
  parameter int         TIMEOUT_CLKS = 3480
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_pl_valid,
  output logic [7:0] o_pl_byte,
  output logic       o_pl_last,
  input  logic       i_pl_ready,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);

  localparam int AW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  // The counter reads TIMEOUT_CLKS-2 in the cycle whose closing edge would
  // take it to TIMEOUT_CLKS-1; the timeout is declared at that edge.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);

  state_t          state_q, state_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [7:0]      acc_q, acc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  err_code_t       code_q, code_d;

  logic            in_frame;
  logic            tmo_hit;
  logic            draining;
  logic            handshake;
  logic            len_ok;
  logic            csum_ok;
  logic            buf_we;
  logic [AW-1:0]   wptr_inc;
  logic [7:0]      buf_rdata;

  assign in_frame  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
  // A byte arriving on the terminal-count cycle takes priority over the timeout.
  assign tmo_hit   = in_frame && !i_rx_dv && (tmo_q == TMO_LAST);
  assign draining  = (state_q == ST_DRAIN);
  assign handshake = draining && i_pl_ready;
  assign len_ok    = len_valid(i_rx_byte, MAX_LEN);
  assign csum_ok   = (i_rx_byte == acc_q);
  assign wptr_inc  = wptr_q + AW'(1);

  assign o_pl_valid  = draining;
  assign o_pl_byte   = draining ? buf_rdata : 8'h00;
  assign o_pl_last   = draining && (rptr_q == len_q - AW'(1));
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;
  assign o_busy      = (state_q != ST_IDLE);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (i_clock),
    .we_i    (buf_we),
    .waddr_i (wptr_q),
    .wdata_i (i_rx_byte),
    .raddr_i (rptr_q),
    .rdata_o (buf_rdata)
  );

  // FSM state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: frame walk, error exits, and drain completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SOF_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (i_rx_dv)      state_d = len_ok ? ST_PAYLOAD : ST_IDLE;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (i_rx_dv) begin
          if (wptr_inc == len_q) state_d = ST_CSUM;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_CSUM: begin
        if (i_rx_dv)      state_d = csum_ok ? ST_DRAIN : ST_IDLE;
        else if (tmo_hit) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (handshake && o_pl_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: buffer writes, checksum, pointers, timeout and status pulses.
  always_comb begin
    len_d  = len_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    acc_d  = acc_q;
    tmo_d  = '0;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    code_d = code_q;
    buf_we = 1'b0;

    if (in_frame && !i_rx_dv && !tmo_hit) tmo_d = tmo_q + TW'(1);
    if (tmo_hit) begin
      err_d  = 1'b1;
      code_d = ERR_TIMEOUT;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_rx_dv && (i_rx_byte == SOF_BYTE)) acc_d = 8'h00;
      end
      ST_LEN: begin
        if (i_rx_dv) begin
          if (!len_ok) begin
            err_d  = 1'b1;
            code_d = ERR_LEN;
          end else begin
            len_d  = AW'(i_rx_byte);
            acc_d  = i_rx_byte;
            wptr_d = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_dv) begin
          buf_we = 1'b1;
          acc_d  = acc_q ^ i_rx_byte;
          wptr_d = wptr_inc;
        end
      end
      ST_CSUM: begin
        if (i_rx_dv) begin
          if (csum_ok) begin
            ok_d   = 1'b1;
            rptr_d = '0;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CSUM;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake) rptr_d = rptr_q + AW'(1);
        // The sink still owns the buffer, so any new byte is dropped.
        if (i_rx_dv) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      len_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      acc_q  <= '0;
      tmo_q  <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      code_q <= ERR_OVERRUN;
    end else begin
      len_q  <= len_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      acc_q  <= acc_d;
      tmo_q  <= tmo_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: directed frames plus randomized frame
// mixes, compared against a byte-list parsing model of the frame format.
module tb_uart_rx_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 3480;
  localparam int EV_OK   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       pl_ready = 1'b1;
  logic       o_pl_valid;
  logic [7:0] o_pl_byte;
  logic       o_pl_last;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  logic [7:0] tx_q[$];
  int         ev_q[$];
  int         exp_ev[$];
  logic [8:0] pl_q[$];
  logic [8:0] exp_pl[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  uart_rx_frame_parser dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_rx_dv     (rx_dv),
    .i_rx_byte   (rx_byte),
    .o_pl_valid  (o_pl_valid),
    .o_pl_byte   (o_pl_byte),
    .o_pl_last   (o_pl_last),
    .i_pl_ready  (pl_ready),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err),
    .o_err_code  (o_err_code),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sink readiness pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       pl_ready = 1'b1;
        1:       pl_ready = 1'($urandom_range(0, 1));
        2:       pl_ready = ~pl_ready;
        default: pl_ready = 1'b0;
      endcase
    end
  end

  // Monitor: collect transfers and status pulses, check stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", o_pl_valid, 1);
        check("hold_byte", o_pl_byte, prev_byte);
      end
      if (o_pl_valid && pl_ready) pl_q.push_back({o_pl_last, o_pl_byte});
      if (o_frame_ok || o_frame_err) begin
        check("ok_err_excl", o_frame_ok & o_frame_err, 0);
        ev_q.push_back(o_frame_ok ? EV_OK : int'(o_err_code));
      end
      prev_stall <= o_pl_valid && !pl_ready;
      prev_byte  <= o_pl_byte;
    end
  end

  // Reference: parse the sent byte list by the frame rules.
  function automatic void model();
    int i = 0;
    int len;
    logic [7:0] x;
    while (i < tx_q.size()) begin
      if (tx_q[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= tx_q.size()) break;
      len = int'(tx_q[i+1]);
      if (len == 0 || len > MAX_LEN) begin
        exp_ev.push_back(1);
        i += 2;
        continue;
      end
      if (i + 2 + len >= tx_q.size()) break;
      x = 8'(len);
      for (int k = 0; k < len; k++) x ^= tx_q[i+2+k];
      if (x == tx_q[i+2+len]) begin
        exp_ev.push_back(EV_OK);
        for (int k = 0; k < len; k++) exp_pl.push_back({k == len - 1, tx_q[i+2+k]});
      end else begin
        exp_ev.push_back(2);
      end
      i += len + 3;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_all(input int maxgap);
    foreach (tx_q[k]) send_byte(tx_q[k], $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    @(negedge clk);
    while (o_busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check({tag, ":idle"}, o_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    check({tag, ":nev"}, ev_q.size(), exp_ev.size());
    foreach (exp_ev[k]) check({tag, ":ev"}, (k < ev_q.size()) ? ev_q[k] : -1, exp_ev[k]);
    check({tag, ":npl"}, pl_q.size(), exp_pl.size());
    foreach (exp_pl[k]) check({tag, ":pl"}, (k < pl_q.size()) ? 32'(pl_q[k]) : 32'hFFFF, 32'(exp_pl[k]));
    ev_q.delete();
    pl_q.delete();
    exp_ev.delete();
    exp_pl.delete();
  endtask

  task automatic frame(input string tag);
    send_all(3);
    wait_idle(tag);
    compare(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":flags"}, {o_pl_valid, o_pl_last, o_frame_ok, o_frame_err, o_busy}, 0);
    check({tag, ":byte"}, o_pl_byte, 0);
    check({tag, ":code"}, o_err_code, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int len;
    int kind;
    logic [7:0] cs;
    logic [7:0] b;

    rst = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // Noise then a one-byte frame.
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h17E};
    frame("noise");

    // Backpressure with toggling ready.
    rdy_mode = 2;
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h011, 9'h022, 9'h133};
    frame("bp");
    rdy_mode = 0;

    // Bad checksum, then recovery.
    tx_q = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    exp_ev = '{2};
    frame("badcs");
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h17E};
    frame("badcs_rec");

    // Bad lengths, then recovery; error code holds after the good frame.
    tx_q = '{8'hA5, 8'h00};
    exp_ev = '{1};
    frame("len0");
    tx_q = '{8'hA5, 8'h11};
    exp_ev = '{1};
    frame("len17");
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h17E};
    frame("len_rec");
    check("code_hold", o_err_code, 1);

    // Timeout: error pulse TMO-1 edges after the last byte strobe edge.
    send_byte(8'hA5, 2);
    send_byte(8'h04, 2);
    @(posedge clk);
    #1;
    rx_dv = 1'b1;
    rx_byte = 8'h01;
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
    n = 0;
    while (n < 2 * TMO) begin
      @(posedge clk);
      #1;
      n++;
      if (o_frame_err) break;
    end
    check("tmo_lat", n, TMO - 1);
    check("tmo_code", o_err_code, 3);
    exp_ev = '{3};
    wait_idle("tmo");
    compare("tmo");

    // Overrun: SOF strobed while a frame is stalled in drain.
    rdy_mode = 3;
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_all(2);
    send_byte(8'hA5, 2);
    rdy_mode = 0;
    exp_ev = '{EV_OK, 0};
    exp_pl = '{9'h17E};
    wait_idle("ovr");
    compare("ovr");
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h17E};
    frame("ovr_rec");

    // Reset mid-payload.
    tx_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_all(2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev = '{EV_OK};
    exp_pl = '{9'h17E};
    frame("rst_rec");

    // Randomized frame mix with random sink readiness.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      tx_q.delete();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h00;
        tx_q.push_back(b);
      end
      kind = $urandom_range(0, 3);
      tx_q.push_back(8'hA5);
      if (kind == 3) begin
        tx_q.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        tx_q.push_back(8'(len));
        cs = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          tx_q.push_back(b);
          cs ^= b;
        end
        if (kind == 2) cs ^= 8'($urandom_range(1, 255));
        tx_q.push_back(cs);
      end
      model();
      send_all(5);
      wait_idle("rand");
      compare("rand");
    end
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
